// File: rtl/reg_file_2r1w_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared sizing constants and word type for the 2R1W register file
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int          RF_WIDTH = 32;
  localparam int          RF_DEPTH = 32;
  localparam int          RF_AW    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/reg_file_2r1w_if.sv
// ============================================================================
// Module  : reg_file_2r1w_if
// Brief   : Write-port and dual read-port bundle between datapath and regfile
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_2r1w_if
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_vld_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_vld_b;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rd_data_a, rd_vld_a, rd_data_b, rd_vld_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rd_data_a, rd_vld_a, rd_data_b, rd_vld_b
  );

endinterface : reg_file_2r1w_if

`default_nettype wire

// File: rtl/reg_file_2r1w_rd_port.sv
// ============================================================================
// Module  : rf_read_port
// Brief   : Registered read port with write-first bypass and valid flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_rd_en,
  input  wire logic [AW-1:0]    i_rd_addr,
  input  wire logic [WIDTH-1:0] i_mem_data,
  input  wire logic             i_wr_en,
  input  wire logic [AW-1:0]    i_wr_addr,
  input  wire logic [WIDTH-1:0] i_wr_data,
  output logic      [WIDTH-1:0] o_rd_data,
  output logic                  o_rd_vld
);

  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_vld;
  logic             w_is_zero;
  logic             w_bypass;

  assign w_is_zero = (i_rd_addr == AW'(REG_ZERO));
  assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr);

  // Address 0 wins over the bypass so a write aimed at r0 never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= i_rd_en;
      if (i_rd_en) begin
        if (w_is_zero)
          r_rd_data <= '0;
        else if (w_bypass)
          r_rd_data <= i_wr_data;
        else
          r_rd_data <= i_mem_data;
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_rd_vld  = r_rd_vld;

endmodule : rf_read_port

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ============================================================================
// Module  : reg_file_2r1w
// Brief   : 32x32 MIPS-style register file, one write and two registered reads
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  reg_file_2r1w_if.slave  bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_mem_a;
  logic [WIDTH-1:0] w_mem_b;
  logic             w_wr_ok;

  assign w_wr_ok = bus.wr_en && (bus.wr_addr != AW'(REG_ZERO));

  // Entry 0 is only ever cleared, which keeps r0 hard-wired to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign w_mem_a = r_mem[bus.rd_addr_a];
  assign w_mem_b = r_mem[bus.rd_addr_b];

  rf_read_port #(.WIDTH(WIDTH), .AW(AW)) u_rd_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_en    (bus.rd_en_a),
    .i_rd_addr  (bus.rd_addr_a),
    .i_mem_data (w_mem_a),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .o_rd_data  (bus.rd_data_a),
    .o_rd_vld   (bus.rd_vld_a)
  );

  rf_read_port #(.WIDTH(WIDTH), .AW(AW)) u_rd_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_en    (bus.rd_en_b),
    .i_rd_addr  (bus.rd_addr_b),
    .i_mem_data (w_mem_b),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .o_rd_data  (bus.rd_data_b),
    .o_rd_vld   (bus.rd_vld_b)
  );

endmodule : reg_file_2r1w

`default_nettype wire
